// File: rtl/ori_vfetch.sv
// Video timing and fetch sequencer: walks pixel phase / byte slot / line on the
// pixel enable, issues video RAM reads, strobes byte loads and generates sync/blank.
module ori_vfetch #(
  parameter int H_TOTAL  = 80,
  parameter int H_ACT    = 48,
  parameter int V_TOTAL  = 312,
  parameter int V_ACT    = 256,
  parameter int HS_START = 60,
  parameter int HS_LEN   = 6,
  parameter int VS_START = 275,
  parameter int VS_LEN   = 4
) (
  input  logic        clk_i,
  input  logic        por_i,
  input  logic        cke_10m_i,
  input  logic [1:0]  scr_sel_i,
  input  logic [2:0]  vmode_i,
  output logic [15:0] vaddr_o,
  output logic        vid_rd_o,
  output logic        cke_pix_o,
  output logic [2:0]  vmode_o,
  output logic        blank_o,
  output logic        hsync_o,
  output logic        vsync_o
);

  localparam logic [6:0] H_LAST = 7'(H_TOTAL - 1);
  localparam logic [6:0] H_ACT_W = 7'(H_ACT);
  localparam logic [6:0] HS_S = 7'(HS_START);
  localparam logic [6:0] HS_E = 7'(HS_START + HS_LEN);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_ACT_W = 9'(V_ACT);
  localparam logic [8:0] VS_S = 9'(VS_START);
  localparam logic [8:0] VS_E = 9'(VS_START + VS_LEN);

  logic [2:0]  phase, phase_n;
  logic [6:0]  hbyte, hbyte_n;
  logic [8:0]  line, line_n;
  logic [1:0]  scr_q, scr_n;
  logic        frame_start;
  logic        fetch_cur, fetch_n;
  logic [15:0] vaddr_n;
  logic        rd_n, blank_n, hs_n, vs_n;

  // Next-position decode; outputs are computed from the post-tick position so
  // they line up with the counters they describe.
  always_comb begin
    phase_n = phase + 3'd1;
    hbyte_n = hbyte;
    line_n  = line;
    if (phase == 3'd7) begin
      hbyte_n = (hbyte == H_LAST) ? 7'd0 : hbyte + 7'd1;
      if (hbyte == H_LAST) begin
        line_n = (line == V_LAST) ? 9'd0 : line + 9'd1;
      end
    end
    frame_start = (phase == 3'd7) && (hbyte == H_LAST) && (line == V_LAST);
    scr_n       = frame_start ? scr_sel_i : scr_q;
    fetch_cur   = (hbyte < H_ACT_W) && (line < V_ACT_W);
    fetch_n     = (hbyte_n < H_ACT_W) && (line_n < V_ACT_W);
    vaddr_n     = {~scr_n, 14'h0} | (16'(hbyte_n) << 8) | {8'h00, line_n[7:0]};
    rd_n        = fetch_n && (phase_n <= 3'd5);
    // Display runs one slot behind the fetch, hence the 1..H_ACT window.
    blank_n     = !((hbyte_n >= 7'd1) && (hbyte_n <= H_ACT_W) && (line_n < V_ACT_W));
    hs_n        = !((hbyte_n >= HS_S) && (hbyte_n < HS_E));
    vs_n        = !((line_n >= VS_S) && (line_n < VS_E));
  end

  // Byte-load handshake: vid_rd_o requests the byte at vaddr_o for phases 0..5 of
  // a fetch slot; cke_pix_o is the single-cycle strobe on the phase-7 tick at
  // which the serializer must take that byte (load wins over its 8th shift).
  assign cke_pix_o = cke_10m_i && !por_i && fetch_cur && (phase == 3'd7);

  always_ff @(posedge clk_i) begin
    if (por_i) begin
      phase    <= 3'd0;
      hbyte    <= 7'd0;
      line     <= 9'd0;
      scr_q    <= 2'd0;
      vmode_o  <= 3'd0;
      vaddr_o  <= 16'hC000;
      vid_rd_o <= 1'b0;
      blank_o  <= 1'b1;
      hsync_o  <= 1'b1;
      vsync_o  <= 1'b1;
    end else if (cke_10m_i) begin
      phase    <= phase_n;
      hbyte    <= hbyte_n;
      line     <= line_n;
      scr_q    <= scr_n;
      if (frame_start) begin
        vmode_o <= vmode_i;
      end
      vaddr_o  <= vaddr_n;
      vid_rd_o <= rd_n;
      blank_o  <= blank_n;
      hsync_o  <= hs_n;
      vsync_o  <= vs_n;
    end
  end

endmodule

// File: tb/tb_ori_vfetch.sv
// Randomised bench for ori_vfetch against a tick-count reference model, with a
// reduced line count per frame so several frame boundaries fit in a short run.
module tb_ori_vfetch;

  localparam int HT = 80;
  localparam int HA = 48;
  localparam int VT = 16;
  localparam int VA = 8;
  localparam int HS = 60;
  localparam int HL = 6;
  localparam int VS = 11;
  localparam int VL = 2;
  localparam int FT = 8 * HT * VT;

  logic        clk = 1'b0;
  logic        por = 1'b0;
  logic        cke = 1'b0;
  logic [1:0]  scr_sel = 2'd0;
  logic [2:0]  vmode = 3'd0;
  logic [15:0] vaddr;
  logic        vid_rd, cke_pix, blank, hsync, vsync;
  logic [2:0]  vmode_q;

  int checks = 0;
  int failures = 0;

  // {pix, vmode, vsync, hsync, blank, vid_rd, vaddr}
  logic [23:0] exp_q[$];

  int          t = 0;
  logic [1:0]  scr_m = 2'd0;
  logic [2:0]  vm_m = 3'd0;
  bit          drv_done = 1'b0;

  ori_vfetch #(
    .H_TOTAL(HT), .H_ACT(HA), .V_TOTAL(VT), .V_ACT(VA),
    .HS_START(HS), .HS_LEN(HL), .VS_START(VS), .VS_LEN(VL)
  ) dut (
    .clk_i(clk), .por_i(por), .cke_10m_i(cke), .scr_sel_i(scr_sel), .vmode_i(vmode),
    .vaddr_o(vaddr), .vid_rd_o(vid_rd), .cke_pix_o(cke_pix), .vmode_o(vmode_q),
    .blank_o(blank), .hsync_o(hsync), .vsync_o(vsync)
  );

  always #5 clk = ~clk;

  function automatic bit fetch_at(input int tt);
    int hb, ln;
    hb = (tt / 8) % HT;
    ln = (tt / (8 * HT)) % VT;
    return (hb < HA) && (ln < VA);
  endfunction

  function automatic logic [23:0] model_out(input int tt, input logic [1:0] s,
                                            input logic [2:0] vm, input bit pix);
    int ph, hb, ln;
    logic [15:0] a;
    bit rd, bl, hs, vs;
    ph = tt % 8;
    hb = (tt / 8) % HT;
    ln = (tt / (8 * HT)) % VT;
    a  = {~s, 14'h0} | 16'(hb * 256) | 16'(ln % 256);
    rd = fetch_at(tt) && (ph <= 5);
    bl = !(hb >= 1 && hb <= HA && ln < VA);
    hs = !(hb >= HS && hb < HS + HL);
    vs = !(ln >= VS && ln < VS + VL);
    return {pix, vm, vs, hs, bl, rd, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock cycle, driven at the negedge; a tick pushes the expected result.
  task automatic do_cycle(input bit ck);
    bit pix;
    cke = ck;
    if (ck) begin
      pix = fetch_at(t) && (t % 8 == 7);
      t++;
      if (t % FT == 0) begin
        scr_m = scr_sel;
        vm_m  = vmode;
      end
      exp_q.push_back(model_out(t, scr_m, vm_m, pix));
    end
    @(negedge clk);
    cke = 1'b0;
  endtask

  // gap < 0: random idle cycles between ticks; otherwise a fixed gap.
  task automatic run_ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap < 0) ? (($urandom_range(0, 3) == 0) ? 1 : 0) : gap;
      for (int k = 0; k < g; k++) do_cycle(1'b0);
      do_cycle(1'b1);
    end
  endtask

  task automatic do_reset(input bit ck);
    por = 1'b1;
    t = 0;
    scr_m = 2'd0;
    vm_m = 3'd0;
    exp_q.push_back({1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 16'hC000});
    cke = ck;
    @(negedge clk);
    por = 1'b0;
    cke = 1'b0;
  endtask

  // Monitor: strobe sampled just before the edge, registers just after it.
  initial begin
    logic [23:0] e, last_e;
    bit act, p;
    last_e = '0;
    forever begin
      @(negedge clk);
      #2;
      act = cke | por;
      p = cke_pix;
      @(posedge clk);
      #1;
      if (act) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty got=tick expected=none");
        end else begin
          e = exp_q.pop_front();
          check("cke_pix", 32'(p), 32'(e[23]));
          check("tick_outputs", 32'({vmode_q, vsync, hsync, blank, vid_rd, vaddr}), 32'(e[22:0]));
          last_e = e;
        end
      end else begin
        check("idle_pix", 32'(p), 32'(0));
        check("idle_hold", 32'({vmode_q, vsync, hsync, blank, vid_rd, vaddr}), 32'(last_e[22:0]));
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset(1'b0);
    check("reset_vaddr", 32'(vaddr), 32'h0000C000);
    check("reset_flags", 32'({vid_rd, blank, hsync, vsync, vmode_q}), 32'({1'b0, 1'b1, 1'b1, 1'b1, 3'd0}));
    do_reset(1'b1);
    check("reset_dominance_vaddr", 32'(vaddr), 32'h0000C000);

    scr_sel = 2'd1;
    vmode = 3'd4;
    run_ticks(FT, 3);
    check("frame1_vmode", 32'(vmode_q), 32'd4);
    run_ticks(5 * 8 * HT + 47 * 8, -1);
    check("l5s47_vaddr", 32'(vaddr), 32'h0000AF05);
    check("l5s47_rd_ph0", 32'(vid_rd), 32'd1);
    run_ticks(5, -1);
    check("l5s47_rd_ph5", 32'(vid_rd), 32'd1);
    run_ticks(1, -1);
    check("l5s47_rd_ph6", 32'(vid_rd), 32'd0);
    run_ticks(1, -1);
    check("l5s47_vaddr_ph7", 32'(vaddr), 32'h0000AF05);

    scr_sel = 2'd2;
    vmode = 3'd6;
    run_ticks(2 * 8 * HT, -1);
    check("midframe_page", 32'(vaddr[15:14]), 32'd2);
    check("midframe_vmode", 32'(vmode_q), 32'd4);
    run_ticks(FT - (t % FT), -1);
    check("frame2_vaddr", 32'(vaddr), 32'h00004000);
    check("frame2_vmode", 32'(vmode_q), 32'd6);

    for (int c = 0; c < 16; c++) begin
      run_ticks($urandom_range(50, 400), -1);
      scr_sel = 2'($urandom_range(0, 3));
      vmode = 3'($urandom_range(0, 7));
    end

    run_ticks((11 - (t % 8)) % 8, -1);
    do_reset(1'b1);
    check("midrun_reset_vaddr", 32'(vaddr), 32'h0000C000);
    check("midrun_reset_flags", 32'({blank, hsync, vsync}), 32'({1'b1, 1'b1, 1'b1}));

    run_ticks(777, -1);
    for (int i = 0; i < 1000; i++) do_cycle(1'b0);
    scr_sel = 2'd3;
    vmode = 3'd5;
    run_ticks(3000, -1);
    do_cycle(1'b0);
    do_cycle(1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    drv_done = 1'b1;
  end

  initial begin
    fork
      wait (drv_done);
      begin
        #2000000;
        checks++;
        failures++;
        $display("FAIL timeout got=running expected=done");
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
